// File: rtl/xaddrgen_pkg.sv
// Shared definitions for the nested-loop address generator: FSM state encoding and default widths.
package xaddrgen_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_PERIOD_W = 10;
    localparam int DEF_ITER_W   = 10;
    localparam int DEF_DELAY_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } agState_e;

endpackage

// File: rtl/xaddrgen.sv
// Two-level nested-loop address generator for one memory port.
// It is started by a one-cycle run pulse, drives registered addr/mem_en and reports completion on done.
module xaddrgen
    import xaddrgen_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int ITER_W   = DEF_ITER_W,
    parameter int DELAY_W  = DEF_DELAY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                pause,
    input  logic [ADDR_W-1:0]   start,
    input  logic [ADDR_W-1:0]   incr,
    input  logic [ADDR_W-1:0]   shift,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [ITER_W-1:0]   iterations,
    input  logic [DELAY_W-1:0]  delay,
    output logic [ADDR_W-1:0]   addr,
    output logic                mem_en,
    output logic                done
);

    localparam logic [PERIOD_W-1:0] PER_ONE = 1;
    localparam logic [ITER_W-1:0]   IT_ONE  = 1;
    localparam logic [DELAY_W-1:0]  DLY_ONE = 1;

    agState_e            stateQ, stateD;
    logic [ADDR_W-1:0]   addrQ, addrD;
    logic [PERIOD_W-1:0] perQ, perD;
    logic [ITER_W-1:0]   itQ, itD;
    logic [DELAY_W-1:0]  dlyQ, dlyD;
    logic                memEnQ, memEnD;
    logic                doneQ, doneD;
    logic                pauseQ, pauseD;

    logic [ADDR_W-1:0]   incrQ, incrD;
    logic [ADDR_W-1:0]   shiftQ, shiftD;
    logic [PERIOD_W-1:0] periodQ, periodD;
    logic [PERIOD_W-1:0] dutyQ, dutyD;
    logic [ITER_W-1:0]   iterQ, iterD;
    logic [DELAY_W-1:0]  delayQ, delayD;

    logic                lastPer;
    logic                lastIt;
    logic                activeNow;
    logic [ADDR_W-1:0]   incrTerm;
    logic [ADDR_W-1:0]   shiftTerm;

    assign lastPer   = (perQ == periodQ - PER_ONE);
    assign lastIt    = (itQ == iterQ - IT_ONE);
    assign activeNow = (perQ < dutyQ);
    assign incrTerm  = activeNow ? incrQ : '0;
    assign shiftTerm = lastPer ? shiftQ : '0;

    // Counters, address and FSM advance only on cycles whose pause was sampled low;
    // mem_en is registered, so a pause sampled at an edge blanks the following cycle.
    always_comb begin
        stateD  = stateQ;
        addrD   = addrQ;
        perD    = perQ;
        itD     = itQ;
        dlyD    = dlyQ;
        incrD   = incrQ;
        shiftD  = shiftQ;
        periodD = periodQ;
        dutyD   = dutyQ;
        iterD   = iterQ;
        delayD  = delayQ;

        case (stateQ)
            IDLE: begin
                if (run) begin
                    incrD   = incr;
                    shiftD  = shift;
                    periodD = period;
                    dutyD   = (duty > period) ? period : duty;
                    iterD   = iterations;
                    delayD  = delay;
                    addrD   = start;
                    perD    = '0;
                    itD     = '0;
                    dlyD    = '0;
                    if (period == '0 || iterations == '0) begin
                        stateD = IDLE;
                    end else if (delay != '0) begin
                        stateD = DELAY;
                    end else begin
                        stateD = RUN;
                    end
                end
            end
            DELAY: begin
                if (!pauseQ) begin
                    if (dlyQ == delayQ - DLY_ONE) begin
                        dlyD   = '0;
                        stateD = RUN;
                    end else begin
                        dlyD = dlyQ + DLY_ONE;
                    end
                end
            end
            RUN: begin
                if (!pauseQ) begin
                    addrD = addrQ + incrTerm + shiftTerm;
                    if (lastPer) begin
                        perD = '0;
                        if (lastIt) begin
                            stateD = IDLE;
                        end else begin
                            itD = itQ + IT_ONE;
                        end
                    end else begin
                        perD = perQ + PER_ONE;
                    end
                end
            end
            default: stateD = IDLE;
        endcase

        pauseD = pause && (stateQ != IDLE);
        memEnD = (stateD == RUN) && !pauseD && (perD < dutyD);
        doneD  = (stateD == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            addrQ   <= '0;
            perQ    <= '0;
            itQ     <= '0;
            dlyQ    <= '0;
            memEnQ  <= 1'b0;
            doneQ   <= 1'b1;
            pauseQ  <= 1'b0;
            incrQ   <= '0;
            shiftQ  <= '0;
            periodQ <= '0;
            dutyQ   <= '0;
            iterQ   <= '0;
            delayQ  <= '0;
        end else begin
            stateQ  <= stateD;
            addrQ   <= addrD;
            perQ    <= perD;
            itQ     <= itD;
            dlyQ    <= dlyD;
            memEnQ  <= memEnD;
            doneQ   <= doneD;
            pauseQ  <= pauseD;
            incrQ   <= incrD;
            shiftQ  <= shiftD;
            periodQ <= periodD;
            dutyQ   <= dutyD;
            iterQ   <= iterD;
            delayQ  <= delayD;
        end
    end

    assign addr   = addrQ;
    assign mem_en = memEnQ;
    assign done   = doneQ;

endmodule

// File: tb/tb_xaddrgen.sv
// Directed self-checking bench for xaddrgen: expected addr/mem_en traces are hand-computed per test.
module tb_xaddrgen;

    localparam int AW = 10;
    localparam int PW = 10;
    localparam int IW = 10;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          pause;
    logic [AW-1:0] start;
    logic [AW-1:0] incr;
    logic [AW-1:0] shift;
    logic [PW-1:0] period;
    logic [PW-1:0] duty;
    logic [IW-1:0] iterations;
    logic [DW-1:0] delay;
    logic [AW-1:0] addr;
    logic          mem_en;
    logic          done;

    int passCount  = 0;
    int checkCount = 0;

    logic          expEnV[32];
    logic [AW-1:0] expAddrV[32];
    logic          pauseV[32];
    logic          runV[32];

    xaddrgen dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pause      (pause),
        .start      (start),
        .incr       (incr),
        .shift      (shift),
        .period     (period),
        .duty       (duty),
        .iterations (iterations),
        .delay      (delay),
        .addr       (addr),
        .mem_en     (mem_en),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so outputs are stable when sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] inc,
                                 input logic [AW-1:0] sh, input logic [PW-1:0] per,
                                 input logic [PW-1:0] du, input logic [IW-1:0] it,
                                 input logic [DW-1:0] dl);
        start      = s;
        incr       = inc;
        shift      = sh;
        period     = per;
        duty       = du;
        iterations = it;
        delay      = dl;
        run        = 1'b1;
        step();
        run        = 1'b0;
    endtask

    task automatic clearVec();
        for (int i = 0; i < 32; i++) begin
            expEnV[i]   = 1'b0;
            expAddrV[i] = '0;
            pauseV[i]   = 1'b0;
            runV[i]     = 1'b0;
        end
    endtask

    task automatic setVec(input int i, input logic en, input logic [AW-1:0] a);
        expEnV[i]   = en;
        expAddrV[i] = a;
    endtask

    task automatic playTrace(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s[%0d].mem_en", tag, i), {31'b0, mem_en}, {31'b0, expEnV[i]});
            checkOutput($sformatf("%s[%0d].addr", tag, i), {22'b0, addr}, {22'b0, expAddrV[i]});
            checkOutput($sformatf("%s[%0d].done", tag, i), {31'b0, done}, 32'd0);
            pause = pauseV[i];
            run   = runV[i];
            step();
        end
        pause = 1'b0;
        run   = 1'b0;
        checkOutput($sformatf("%s.end.done", tag), {31'b0, done}, 32'd1);
        checkOutput($sformatf("%s.end.mem_en", tag), {31'b0, mem_en}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; pause = 1'b0;
        start = '0; incr = '0; shift = '0; period = '0; duty = '0; iterations = '0; delay = '0;

        // Reset, with run and pause asserted to confirm reset wins.
        step();
        run = 1'b1; pause = 1'b1;
        step();
        checkOutput("reset.addr", {22'b0, addr}, 32'd0);
        checkOutput("reset.mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("reset.done", {31'b0, done}, 32'd1);
        rst = 1'b0; run = 1'b0; pause = 1'b0;
        step();
        checkOutput("idle.done", {31'b0, done}, 32'd1);

        // Test 1: basic run; config changes after run must not matter.
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd3, 10'd3, 10'd2, 5'd0);
        start = 10'd100; incr = 10'd5; period = 10'd7;
        clearVec();
        for (int i = 0; i < 6; i++) setVec(i, 1'b1, 10'(4 + i));
        playTrace("basic", 6);
        checkOutput("basic.final_addr", {22'b0, addr}, 32'd10);

        // Test 2: duty gaps plus end-of-period shift.
        applyStimulus(10'd0, 10'd1, 10'd10, 10'd4, 10'd2, 10'd2, 5'd0);
        clearVec();
        setVec(0, 1'b1, 10'd0);  setVec(1, 1'b1, 10'd1);
        setVec(2, 1'b0, 10'd2);  setVec(3, 1'b0, 10'd2);
        setVec(4, 1'b1, 10'd12); setVec(5, 1'b1, 10'd13);
        setVec(6, 1'b0, 10'd14); setVec(7, 1'b0, 10'd14);
        playTrace("dutyshift", 8);
        checkOutput("dutyshift.final_addr", {22'b0, addr}, 32'd24);

        // Test 3: negative increment wraps modulo 2^10.
        applyStimulus(10'd0, 10'h3FF, 10'd0, 10'd2, 10'd2, 10'd1, 5'd0);
        clearVec();
        setVec(0, 1'b1, 10'd0);
        setVec(1, 1'b1, 10'd1023);
        playTrace("wrap", 2);
        checkOutput("wrap.final_addr", {22'b0, addr}, 32'd1022);

        // Test 4: 3-cycle start delay and a 2-cycle pause after the second active cycle.
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd3, 10'd3, 10'd2, 5'd3);
        clearVec();
        setVec(0, 1'b0, 10'd4);  setVec(1, 1'b0, 10'd4);  setVec(2, 1'b0, 10'd4);
        setVec(3, 1'b1, 10'd4);  setVec(4, 1'b1, 10'd5);
        setVec(5, 1'b0, 10'd6);  setVec(6, 1'b0, 10'd6);
        setVec(7, 1'b1, 10'd6);  setVec(8, 1'b1, 10'd7);
        setVec(9, 1'b1, 10'd8);  setVec(10, 1'b1, 10'd9);
        pauseV[4] = 1'b1;
        pauseV[5] = 1'b1;
        playTrace("delaypause", 11);

        // duty==0: full-length run with no mem_en, only shift moves addr.
        applyStimulus(10'd1, 10'd1, 10'd3, 10'd2, 10'd0, 10'd2, 5'd0);
        clearVec();
        setVec(0, 1'b0, 10'd1); setVec(1, 1'b0, 10'd1);
        setVec(2, 1'b0, 10'd4); setVec(3, 1'b0, 10'd4);
        playTrace("duty0", 4);
        checkOutput("duty0.final_addr", {22'b0, addr}, 32'd7);

        // Test 5a: degenerate runs never drop done.
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd0, 10'd3, 10'd2, 5'd0);
        checkOutput("period0.done", {31'b0, done}, 32'd1);
        checkOutput("period0.mem_en", {31'b0, mem_en}, 32'd0);
        step();
        checkOutput("period0.done2", {31'b0, done}, 32'd1);
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd3, 10'd3, 10'd0, 5'd2);
        checkOutput("iter0.done", {31'b0, done}, 32'd1);
        checkOutput("iter0.mem_en", {31'b0, mem_en}, 32'd0);

        // Test 5b: run while busy is dropped, not queued.
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd3, 10'd3, 10'd2, 5'd0);
        start = 10'd50;
        clearVec();
        for (int i = 0; i < 6; i++) setVec(i, 1'b1, 10'(4 + i));
        runV[1] = 1'b1;
        playTrace("busyrun", 6);
        step();
        checkOutput("busyrun.notqueued.done", {31'b0, done}, 32'd1);
        checkOutput("busyrun.notqueued.mem_en", {31'b0, mem_en}, 32'd0);

        // Test 5c: reset during the third active cycle aborts at once.
        applyStimulus(10'd4, 10'd1, 10'd0, 10'd3, 10'd3, 10'd2, 5'd0);
        checkOutput("abort.a0", {22'b0, addr}, 32'd4);
        step();
        checkOutput("abort.a1", {22'b0, addr}, 32'd5);
        step();
        checkOutput("abort.a2", {22'b0, addr}, 32'd6);
        checkOutput("abort.en2", {31'b0, mem_en}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort.addr", {22'b0, addr}, 32'd0);
        checkOutput("abort.mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("abort.done", {31'b0, done}, 32'd1);
        step();
        checkOutput("abort.after.mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("abort.after.done", {31'b0, done}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
